timer_tc: RTL and testbench

- Programmable down-counter timer on the system bridge; its IRQ output drives one bit of the HWInt[5:0] bus sampled by the coprocessor-0 block.
- CPU programs it via sw/lw through the bridge (word registers CTRL, PRESET, COUNT).
- Supports one-shot (mode 0) and auto-reload periodic (mode 1) operation.
- Interrupt is level-held in mode 0 and a one-cycle pulse in mode 1.

---
 rtl/timer_tc.sv | 137 +++++++++++++
 tb/tb_timer_tc.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tc.sv
// timer_tc: programmable 32-bit down-counter timer on the system bridge.
// The CPU programs CTRL/PRESET and reads COUNT through word registers.
// Mode 0 is one-shot with a level-held interrupt.
// Mode 1 is auto-reload with a single-cycle interrupt pulse.
module timer_tc #(
    parameter logic [31:0] PRESET_INIT = 32'd0,
    parameter logic [31:0] TC_ID       = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_e;

    // CTRL bit positions
    localparam int EN_BIT = 0;
    localparam int IM_BIT = 3;

    logic [3:0]  ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic        irq_flag_q, irq_flag_d;
    state_e      state_q,    state_d;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_reload;

    // TC_ID only tags this instance in the bridge address map; it drives no logic.
    logic unused_tc_id;
    assign unused_tc_id = ^TC_ID;

    assign wr_ctrl     = WE && (Addr == 2'd0);
    assign wr_preset   = WE && (Addr == 2'd1);
    // Only 2'b01 reloads; 2'b1x falls back to one-shot.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    // Next-state logic: one FSM step per cycle, then bus writes override.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        state_d    = state_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[EN_BIT]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[EN_BIT]) begin
                    // Stopped: COUNT freezes where it is.
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // COUNT of 0 or 1 ends the run, so PRESET=0 acts like PRESET=1.
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (auto_reload) begin
                    // Enable stays set, so IDLE re-enters LOAD for the next period.
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[EN_BIT] = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Software writes come last so they win over the internal Enable clear
        // and the flag set. Writing CTRL or PRESET is also the interrupt acknowledge.
        if (wr_ctrl) begin
            ctrl_d     = DIn[3:0];
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = DIn;
            irq_flag_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (!reset) begin
            ctrl_q     <= 4'd0;
            preset_q   <= PRESET_INIT;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            state_q    <= S_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    // Read mux: combinational, so a same-cycle read returns the pre-write value.
    always_comb begin
        DOut = 32'd0;
        case (Addr)
            2'd0:    DOut = {28'd0, ctrl_q};
            2'd1:    DOut = preset_q;
            2'd2:    DOut = count_q;
            default: DOut = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q[IM_BIT];

endmodule

// File: tb/tb_timer_tc.sv
// Self-checking bench for timer_tc.
// The reference model describes a run as an elapsed-cycle position.
// The count it expects is derived arithmetically from that position.
module tb_timer_tc;

    localparam logic [31:0] PRESET_INIT = 32'd0;

    logic        clk;
    logic        reset;
    logic [3:2]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    timer_tc #(
        .PRESET_INIT(PRESET_INIT),
        .TC_ID      (32'h7F11_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Run position m_pos: 0 idle, 1 load, 2.. counting, and the final position is
    // the interrupt cycle, reached max(P,1) cycles after counting starts.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_pos;
    logic [31:0] m_lp;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_flag & m_ctrl[3];
    endfunction

    task automatic model_step(input logic rst_i, input logic we_i,
                              input logic [1:0] a_i, input logic [31:0] d_i);
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset;
        logic [31:0] n_count;
        logic        n_flag;
        int          n_pos;
        longint      last;
        if (!rst_i) begin
            m_ctrl   = 4'd0;
            m_preset = PRESET_INIT;
            m_count  = 32'd0;
            m_flag   = 1'b0;
            m_pos    = 0;
            m_lp     = 32'd0;
        end else begin
            n_ctrl   = m_ctrl;
            n_preset = m_preset;
            n_count  = m_count;
            n_flag   = m_flag;
            n_pos    = m_pos;
            last     = 2 + longint'((m_lp == 32'd0) ? 32'd1 : m_lp);
            if (m_pos == 0) begin
                if (m_ctrl[0]) n_pos = 1;
            end else if (m_pos == 1) begin
                m_lp    = m_preset;
                n_count = m_preset;
                n_pos   = 2;
            end else if (m_pos < last) begin
                if (!m_ctrl[0]) begin
                    n_pos = 0;
                end else if (m_pos + 1 == last) begin
                    n_count = 32'd0;
                    n_flag  = 1'b1;
                    n_pos   = m_pos + 1;
                end else begin
                    n_count = m_lp - 32'(m_pos - 1);
                    n_pos   = m_pos + 1;
                end
            end else begin
                n_pos = 0;
                if (m_ctrl[2:1] == 2'b01) n_flag = 1'b0;
                else n_ctrl[0] = 1'b0;
            end
            if (we_i && a_i == 2'd0) begin
                n_ctrl = d_i[3:0];
                n_flag = 1'b0;
            end
            if (we_i && a_i == 2'd1) begin
                n_preset = d_i;
                n_flag   = 1'b0;
            end
            m_ctrl   = n_ctrl;
            m_preset = n_preset;
            m_count  = n_count;
            m_flag   = n_flag;
            m_pos    = n_pos;
        end
    endtask

    // One clock cycle: drive inputs, take the edge, advance the model, settle.
    task automatic tick(input logic we_i, input logic [1:0] a_i, input logic [31:0] d_i);
        WE   = we_i;
        Addr = a_i;
        DIn  = d_i;
        @(posedge clk);
        model_step(reset, we_i, a_i, d_i);
        #1;
        WE = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0, 2'd0, 32'd0);
        tick(1'b0, 2'd0, 32'd0);
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) tick(1'b1, 2'(i), 32'hFFFF_FFFF);
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            exp = (a == 1) ? PRESET_INIT : 32'd0;
            checks++;
            if (DOut !== exp) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, DOut, exp);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_one_shot(input logic im);
        logic [31:0] seen[$];
        int  c_cnt;
        int  c_irq;
        logic ok;
        do_reset();
        c_cnt = -1;
        c_irq = -1;
        tick(1'b1, 2'd1, 32'd5);
        tick(1'b1, 2'd0, {28'd0, im, 3'b001});
        for (int c = 0; c < 14; c++) begin
            tick(1'b0, 2'd2, 32'd0);
            checks++;
            if (DOut !== model_read(2'd2)) begin
                errors++;
                $display("FAIL oneshot_count im=%b c=%0d got=%h exp=%h", im, c, DOut, model_read(2'd2));
            end
            checks++;
            if (IRQ !== model_irq()) begin
                errors++;
                $display("FAIL oneshot_irq im=%b c=%0d got=%b exp=%b", im, c, IRQ, model_irq());
            end
            if (DOut != 32'd0) seen.push_back(DOut);
            if (DOut == 32'd5 && c_cnt < 0) c_cnt = c;
            if (IRQ === 1'b1 && c_irq < 0) c_irq = c;
        end
        ok = (seen.size() == 5);
        for (int i = 0; i < seen.size() && i < 5; i++) if (seen[i] != 32'(5 - i)) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL oneshot_sequence im=%b got_len=%0d exp=5,4,3,2,1", im, seen.size());
        end
        Addr = 2'd0;
        #1;
        checks++;
        if (DOut !== {28'd0, im, 3'b000}) begin
            errors++;
            $display("FAIL oneshot_ctrl_after im=%b got=%h exp=%h", im, DOut, {28'd0, im, 3'b000});
        end
        if (im) begin
            checks++;
            if (c_irq - c_cnt != 5 || c_cnt < 0) begin
                errors++;
                $display("FAIL oneshot_irq_delay got=%0d exp=5", c_irq - c_cnt);
            end
            checks++;
            if (IRQ !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_irq_held got=%b exp=1", IRQ);
            end
            tick(1'b1, 2'd0, 32'd0);
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_ack got=%b exp=0", IRQ);
            end
        end else begin
            checks++;
            if (c_irq != -1) begin
                errors++;
                $display("FAIL mask_irq_seen got=%0d exp=-1", c_irq);
            end
            // IM set, Enable cleared: a flag left set would now show on IRQ.
            tick(1'b1, 2'd0, 32'h8);
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL mask_ack got=%b exp=0", IRQ);
            end
        end
    endtask

    task automatic test_periodic(input logic [31:0] p, input int period, input int ncyc);
        int highs[$];
        logic ok;
        do_reset();
        tick(1'b1, 2'd1, p);
        tick(1'b1, 2'd0, 32'hB);
        for (int c = 0; c < ncyc; c++) begin
            tick(1'b0, 2'd2, 32'd0);
            checks++;
            if (DOut !== model_read(2'd2) || IRQ !== model_irq()) begin
                errors++;
                $display("FAIL periodic_model p=%0d c=%0d got=%h/%b exp=%h/%b",
                         p, c, DOut, IRQ, model_read(2'd2), model_irq());
            end
            if (IRQ === 1'b1) highs.push_back(c);
        end
        ok = (highs.size() >= 4);
        for (int i = 1; i < highs.size(); i++) if (highs[i] - highs[i-1] != period) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL periodic_spacing p=%0d pulses=%0d exp_period=%0d", p, highs.size(), period);
        end
    endtask

    task automatic test_stop_resume();
        logic found;
        do_reset();
        tick(1'b1, 2'd1, 32'd10);
        tick(1'b1, 2'd0, 32'd1);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick(1'b0, 2'd2, 32'd0);
            if (DOut === 32'd7) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stop_reach7 got=%h exp=7", DOut);
        end
        // Clear Enable while COUNT steps 7 -> 6; it then freezes at 6.
        tick(1'b1, 2'd0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 2'd2, 32'd0);
            checks++;
            if (DOut !== 32'd6 || DOut !== model_read(2'd2)) begin
                errors++;
                $display("FAIL stop_hold c=%0d got=%h exp=6", c, DOut);
            end
        end
        tick(1'b1, 2'd0, 32'd1);
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            tick(1'b0, 2'd2, 32'd0);
            if (DOut === 32'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL resume_reload got=%h exp=a", DOut);
        end
    endtask

    task automatic test_corners();
        logic found;
        // A write to COUNT is ignored while counting.
        do_reset();
        tick(1'b1, 2'd1, 32'd4);
        tick(1'b1, 2'd0, 32'd1);
        tick(1'b0, 2'd2, 32'd0);
        tick(1'b0, 2'd2, 32'd0);
        tick(1'b1, 2'd2, 32'h1234_5678);
        checks++;
        if (DOut !== 32'd3) begin
            errors++;
            $display("FAIL count_write_ignored got=%h exp=3", DOut);
        end
        tick(1'b1, 2'd3, 32'hFFFF_FFFF);
        checks++;
        if (DOut !== 32'd0) begin
            errors++;
            $display("FAIL addr3_read got=%h exp=0", DOut);
        end
        Addr = 2'd1;
        #1;
        checks++;
        if (DOut !== 32'd4) begin
            errors++;
            $display("FAIL addr3_write_preset got=%h exp=4", DOut);
        end
        Addr = 2'd0;
        #1;
        checks++;
        if (DOut !== 32'd1) begin
            errors++;
            $display("FAIL addr3_write_ctrl got=%h exp=1", DOut);
        end

        // A PRESET write on the same edge that enters INT leaves IRQ low.
        do_reset();
        tick(1'b1, 2'd1, 32'd2);
        tick(1'b1, 2'd0, 32'h9);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick(1'b0, 2'd2, 32'd0);
            if (DOut === 32'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL race_reach1 got=%h exp=1", DOut);
        end
        tick(1'b1, 2'd1, 32'd2);
        checks++;
        if (IRQ !== 1'b0 || IRQ !== model_irq()) begin
            errors++;
            $display("FAIL race_irq got=%b exp=0", IRQ);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 2'd0, 32'd0);
            checks++;
            if (IRQ !== 1'b0 || DOut !== model_read(2'd0)) begin
                errors++;
                $display("FAIL race_after c=%0d got=%b/%h exp=0/%h", c, IRQ, DOut, model_read(2'd0));
            end
        end
    endtask

    task automatic test_random();
        int          r;
        logic        we;
        logic [1:0]  a;
        logic [1:0]  ra;
        logic [31:0] d;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r     = int'($urandom_range(0, 199));
            reset = (r == 0) ? 1'b0 : 1'b1;
            we    = (r < 40);
            a     = 2'($urandom_range(0, 3));
            d     = (a == 2'd1) ? 32'($urandom_range(0, 12)) : $urandom();
            tick(we, a, d);
            checks++;
            if (DOut !== model_read(a) || IRQ !== model_irq()) begin
                errors++;
                $display("FAIL random c=%0d addr=%0d got=%h/%b exp=%h/%b",
                         c, a, DOut, IRQ, model_read(a), model_irq());
            end
            ra   = 2'($urandom_range(0, 3));
            Addr = ra;
            #1;
            checks++;
            if (DOut !== model_read(ra)) begin
                errors++;
                $display("FAIL random_read c=%0d addr=%0d got=%h exp=%h", c, ra, DOut, model_read(ra));
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = 2'd0;
        DIn   = 32'd0;
        m_ctrl   = 4'd0;
        m_preset = PRESET_INIT;
        m_count  = 32'd0;
        m_flag   = 1'b0;
        m_pos    = 0;
        m_lp     = 32'd0;
        test_reset();
        test_one_shot(1'b1);
        test_one_shot(1'b0);
        test_periodic(32'd3, 6, 40);
        test_periodic(32'd0, 4, 30);
        test_stop_resume();
        test_corners();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
